// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard-detection and forwarding controller for the in-order pipeline.
// It sits beside the ID stage. A scoreboard shift register tracks the
// destination registers of instructions in flight from EX (stage 0) to
// WB (stage DEPTH-1). Each cycle it compares the sources of the ID
// instruction against the scoreboard and drives stall, bubble, flush and
// forwarding-select outputs. It also counts stall and flush cycles.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs1/id_rs2, *_use        source registers and their read enables
//   id_rd, id_optype            destination; 00 none, 01 ALU, 10 load, 11 store
//   id_branch_taken             ID resolved a taken branch or jump
//   mem_stall                   freezes the whole pipeline
//   stall_pc, stall_ifid        hold PC and the IF/ID register
//   bubble_idex                 insert a NOP into ID/EX
//   flush_ifid                  squash the IF/ID register
//   fwd_rs1_sel, fwd_rs2_sel    0 = register file, k+1 = result of stage k
//   stall_cycles, flush_count   wrapping performance counters
module hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1use,
    input  logic            id_rs2use,
    input  logic [4:0]      id_rd,
    input  logic [1:0]      id_optype,
    input  logic            id_branch_taken,
    input  logic            mem_stall,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            bubble_idex,
    output logic            flush_ifid,
    output logic [SELW-1:0] fwd_rs1_sel,
    output logic [SELW-1:0] fwd_rs2_sel,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    logic [DEPTH-1:0]      sb_valid;
    logic [DEPTH-1:0]      sb_load;
    logic [DEPTH-1:0][4:0] sb_rd;

    logic [1:0][4:0]       src;
    logic [1:0]            src_use;
    logic [1:0]            src_blocked;
    logic [1:0][SELW-1:0]  src_sel;
    logic                  hz_stall;
    logic                  is_writer;

    assign src     = {id_rs2, id_rs1};
    assign src_use = {id_rs2use, id_rs1use};

    // Scan from the oldest stage down to EX so the youngest match (lowest k)
    // is the one that sticks.
    always_comb begin
        logic rdy_k;
        src_blocked = '0;
        src_sel     = '0;
        rdy_k       = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_valid && src_use[j] && (src[j] != 5'd0) &&
                    sb_valid[k] && (sb_rd[k] == src[j])) begin
                    if (FWD_EN != 0)
                        rdy_k = !sb_load[k] || (k >= LOAD_LAT);
                    else
                        rdy_k = (k == DEPTH - 1);
                    src_blocked[j] = !rdy_k;
                    // WB writes the register file first, so a match there
                    // reads the file directly.
                    if ((FWD_EN != 0) && rdy_k && (k < DEPTH - 1))
                        src_sel[j] = SELW'(k + 1);
                    else
                        src_sel[j] = '0;
                end
            end
        end
    end

    assign hz_stall    = |src_blocked;
    assign fwd_rs1_sel = src_sel[0];
    assign fwd_rs2_sel = src_sel[1];

    assign stall_pc    = mem_stall | hz_stall;
    assign stall_ifid  = mem_stall | hz_stall;
    assign bubble_idex = !mem_stall & hz_stall;
    // Stall wins over a taken branch; the branch is re-evaluated once the
    // operands are ready.
    assign flush_ifid  = !mem_stall & id_valid & id_branch_taken & !hz_stall;

    assign is_writer = ((id_optype == OP_ALU) || (id_optype == OP_LOAD)) &&
                       (id_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_load  <= '0;
            sb_rd    <= '0;
        end else if (!mem_stall) begin
            sb_valid <= {sb_valid[DEPTH-2:0], id_valid & !hz_stall & is_writer};
            sb_load  <= {sb_load[DEPTH-2:0], id_optype == OP_LOAD};
            sb_rd    <= {sb_rd[DEPTH-2:0], id_rd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (hz_stall && !mem_stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_ifid)
                flush_count <= flush_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle vectors against a
// DEPTH=3, LOAD_LAT=1 forwarding instance, then hand-written sequences for
// memory freeze, asynchronous reset and a no-forwarding instance.
module tb_hazard_ctrl;

    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs1use, id_rs2use;
    logic [1:0]      id_optype;
    logic            id_branch_taken;
    logic            mem_stall;

    logic            stall_pc, stall_ifid, bubble_idex, flush_ifid;
    logic [SELW-1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0]     stall_cycles, flush_count;

    logic            nf_stall_pc, nf_stall_ifid, nf_bubble_idex, nf_flush_ifid;
    logic [SELW-1:0] nf_rs1_sel, nf_rs2_sel;
    logic [31:0]     nf_stall_cycles, nf_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use),
        .id_rd(id_rd), .id_optype(id_optype), .id_branch_taken(id_branch_taken),
        .mem_stall(mem_stall), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use),
        .id_rd(id_rd), .id_optype(id_optype), .id_branch_taken(id_branch_taken),
        .mem_stall(mem_stall), .stall_pc(nf_stall_pc), .stall_ifid(nf_stall_ifid),
        .bubble_idex(nf_bubble_idex), .flush_ifid(nf_flush_ifid),
        .fwd_rs1_sel(nf_rs1_sel), .fwd_rs2_sel(nf_rs2_sel),
        .stall_cycles(nf_stall_cycles), .flush_count(nf_flush_count)
    );

    typedef struct {
        int valid, rs1, u1, rs2, u2, rd, op, br;
        int e_stall, e_bubble, e_flush, e_sel1, e_sel2;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int valid, input int rs1, input int u1, input int rs2,
                         input int u2, input int rd, input int op, input int br);
        id_valid        = valid[0];
        id_rs1          = 5'(rs1);
        id_rs1use       = u1[0];
        id_rs2          = 5'(rs2);
        id_rs2use       = u2[0];
        id_rd           = 5'(rd);
        id_optype       = 2'(op);
        id_branch_taken = br[0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           valid rs1 u1 rs2 u2 rd op br  st bub fl s1 s2
        tbl[0]  = '{1, 0, 0,  0, 0,  5, 1, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 1,  0, 0, 10, 1, 0,  0, 0, 0, 1, 0};
        tbl[2]  = '{1, 5, 1, 10, 1,  0, 0, 0,  0, 0, 0, 2, 1};
        tbl[3]  = '{1, 5, 1, 10, 1,  0, 0, 0,  0, 0, 0, 0, 2};
        tbl[4]  = '{1,10, 1,  0, 0,  6, 2, 0,  0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,  6, 1,  0, 1, 0,  1, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,  6, 1,  0, 1, 0,  0, 0, 0, 0, 2};
        tbl[7]  = '{1, 0, 0,  0, 0,  7, 1, 0,  0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0,  0, 0,  7, 1, 0,  0, 0, 0, 0, 0};
        tbl[9]  = '{1, 7, 1,  0, 1,  0, 1, 0,  0, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 1,  0, 1,  9, 3, 0,  0, 0, 0, 0, 0};
        tbl[11] = '{1, 9, 1,  7, 1,  0, 0, 0,  0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0,  0, 0,  0, 0, 1,  0, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 0,  0, 0,  3, 2, 0,  0, 0, 0, 0, 0};
        tbl[14] = '{1, 3, 1,  0, 0,  0, 0, 1,  1, 1, 0, 0, 0};
        tbl[15] = '{1, 3, 1,  0, 0,  0, 0, 1,  0, 0, 1, 2, 0};
        tbl[16] = '{0, 3, 1,  0, 0,  0, 0, 1,  0, 0, 0, 0, 0};

        rst_n     = 1'b0;
        mem_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset stall_pc", 64'(stall_pc), 0);
        check("reset bubble", 64'(bubble_idex), 0);
        check("reset stall_cycles", 64'(stall_cycles), 0);
        check("reset flush_count", 64'(flush_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].valid, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].op, tbl[i].br);
            @(negedge clk);
            check($sformatf("v%0d stall_pc", i), 64'(stall_pc), 64'(tbl[i].e_stall));
            check($sformatf("v%0d stall_ifid", i), 64'(stall_ifid), 64'(tbl[i].e_stall));
            check($sformatf("v%0d bubble", i), 64'(bubble_idex), 64'(tbl[i].e_bubble));
            check($sformatf("v%0d flush", i), 64'(flush_ifid), 64'(tbl[i].e_flush));
            if (tbl[i].e_stall == 0) begin
                check($sformatf("v%0d sel1", i), 64'(fwd_rs1_sel), 64'(tbl[i].e_sel1));
                check($sformatf("v%0d sel2", i), 64'(fwd_rs2_sel), 64'(tbl[i].e_sel2));
            end
            next_cycle();
        end
        check("table stall_cycles", 64'(stall_cycles), 2);
        check("table flush_count", 64'(flush_count), 2);

        // Load held at stage 0 through a three-cycle memory freeze.
        drive(1, 0, 0, 0, 0, 4, 2, 0);
        @(negedge clk);
        check("frz load issue stall", 64'(stall_pc), 0);
        next_cycle();
        drive(1, 4, 1, 0, 0, 0, 0, 0);
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("frz%0d stall_pc", c), 64'(stall_pc), 1);
            check($sformatf("frz%0d stall_ifid", c), 64'(stall_ifid), 1);
            check($sformatf("frz%0d bubble", c), 64'(bubble_idex), 0);
            check($sformatf("frz%0d stall_cycles", c), 64'(stall_cycles), 2);
            next_cycle();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        check("frz release stall", 64'(stall_pc), 1);
        check("frz release bubble", 64'(bubble_idex), 1);
        next_cycle();
        @(negedge clk);
        check("frz fwd stall", 64'(stall_pc), 0);
        check("frz fwd sel1", 64'(fwd_rs1_sel), 2);
        check("frz stall_cycles", 64'(stall_cycles), 3);
        next_cycle();

        // Asynchronous reset with a pending load-use.
        drive(1, 0, 0, 0, 0, 8, 2, 0);
        next_cycle();
        drive(1, 8, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("rst pre stall", 64'(stall_pc), 1);
        check("rst pre flush", 64'(flush_ifid), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst stall_pc", 64'(stall_pc), 0);
        check("rst stall_ifid", 64'(stall_ifid), 0);
        check("rst bubble", 64'(bubble_idex), 0);
        check("rst sel1", 64'(fwd_rs1_sel), 0);
        check("rst flush follows", 64'(flush_ifid), 1);
        check("rst stall_cycles", 64'(stall_cycles), 0);
        check("rst flush_count", 64'(flush_count), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // No-forwarding instance: a dependency waits until the producer is in WB.
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        @(negedge clk);
        check("nf issue stall", 64'(nf_stall_pc), 0);
        next_cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("nf k0 stall", 64'(nf_stall_pc), 1);
        check("nf k0 bubble", 64'(nf_bubble_idex), 1);
        check("fwd k0 sel1", 64'(fwd_rs1_sel), 1);
        check("fwd k0 stall", 64'(stall_pc), 0);
        next_cycle();
        @(negedge clk);
        check("nf k1 stall", 64'(nf_stall_pc), 1);
        next_cycle();
        @(negedge clk);
        check("nf k2 stall", 64'(nf_stall_pc), 0);
        check("nf k2 sel1", 64'(nf_rs1_sel), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("nf stall_cycles", 64'(nf_stall_cycles), 2);
        check("fwd stall_cycles after rst", 64'(stall_cycles), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. It sits beside the ID stage and keeps a scoreboard shift register of the in-flight destination registers from EX through WB. Each cycle it compares the ID instruction's source registers against that scoreboard and drives stall, bubble, flush and forwarding-select signals. It generalises the fixed 5-stage hazard logic to a configurable post-ID depth, a configurable load latency, an optional no-forwarding mode, and a memory-freeze input. It also keeps performance counters for stalls and flushes.

## Interface
- DEPTH, 3: number of tracked stages after ID; stage 0 is EX, stage DEPTH-1 is WB (2..8).
- LOAD_LAT, 1: stage index at which load data becomes forwardable (1..DEPTH-1).
- FWD_EN, 1: 1 enables forwarding; 0 stalls on every dependency until the producer reaches WB.
- SELW, $clog2(DEPTH+1): width of the forwarding selects (derived).
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register addresses.
- id_rs1use, id_rs2use  in  1  source is actually read.
- id_rd  in  5  destination register.
- id_optype  in  2  00 none, 01 ALU writer, 10 load, 11 store.
- id_branch_taken  in  1  ID resolved a taken branch or jump.
- mem_stall  in  1  memory busy; freezes the whole pipeline.
- stall_pc, stall_ifid  out  1  hold PC and the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  squash the IF/ID register.
- fwd_rs1_sel, fwd_rs2_sel  out  SELW  0 = register file; k+1 = result of stage k.
- stall_cycles  out  32  count of hazard-stall cycles.
- flush_count  out  32  count of flushes.

## Operation
- Scoreboard: DEPTH entries, each {valid, rd[4:0], is_load}.
- A writer is an instruction with id_optype 01 or 10 and id_rd != 0. Types 00 and 11 never enter the scoreboard as valid entries.
- Match for source s: id_valid & s_use & s != 0 & entry[k].valid & entry[k].rd == s. The youngest match wins, i.e. the lowest k.
- Readiness of a match at stage k:
  - FWD_EN=1: ready if the entry is not a load and k >= 0, or is a load and k >= LOAD_LAT.
  - FWD_EN=0: ready only if k == DEPTH-1.
- Forward select:
  - No match: sel = 0.
  - Ready match with FWD_EN=1 and k < DEPTH-1: sel = k+1.
  - Match at k == DEPTH-1: sel = 0, because the register file writes first in WB.
- hz_stall = any used source whose youngest match is not ready. Selects are still driven while stalling, but consumers ignore them.
- Freeze (mem_stall=1):
  - All entries and counters hold.
  - stall_pc = stall_ifid = 1; bubble_idex = 0; flush_ifid = 0.
- Normal cycle (mem_stall=0):
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= new writer if id_valid & !hz_stall, else invalid (bubble).
  - stall_pc = stall_ifid = bubble_idex = hz_stall.
  - flush_ifid = id_valid & id_branch_taken & !hz_stall.
- Counters:
  - stall_cycles += 1 on cycles with hz_stall & !mem_stall.
  - flush_count += 1 on cycles where flush_ifid = 1.
  - Both wrap modulo 2^32.
- Simultaneous branch and hazard: the stall has priority. The branch is re-evaluated once operands are ready, so there is no flush while stalled.

## Timing
- Hazard, forwarding and flush outputs are combinational from scoreboard state and ID inputs. There is zero latency: they are valid within the same cycle.
- The scoreboard advances one stage per unfrozen clock. A writer accepted in cycle N sits at stage k during cycle N+1+k, counting only unfrozen cycles.
- Load-use penalty with FWD_EN=1 is LOAD_LAT cycles.
- Reset (asynchronous, any time):
  - All entries are invalidated immediately; counters go to 0.
  - Outputs immediately become stall_pc = stall_ifid = bubble_idex = 0 and sel = 0. flush_ifid follows its inputs.
  - Mid-operation reset drops every pending dependency.
- Deassertion of rst_n is synchronous to clk at the system level. The first edge after deassertion is the first update.

## Test plan
- DEPTH=3, LOAD_LAT=1, FWD_EN=1: issue ALU rd=5 at cycle N, then rs1=5 used at N+1 -> fwd_rs1_sel=1, stall 0. A second dependent instruction at N+2 -> sel=2. At N+3 -> sel=0.
- Issue a load rd=6, then rs2=6 used next cycle:
  - First cycle: stall_pc=stall_ifid=bubble_idex=1.
  - Next cycle: fwd_rs2_sel=2, stall 0.
  - stall_cycles=1.
- Youngest wins and x0 is ignored:
  - rd=7 at stages 0 and 1 -> sel=1.
  - rs1=0 with an entry rd=0 attempted -> sel=0, no stall.
  - A store with id_rd=9 -> later use of 9 gives sel=0.
- Load rd=4 at stage 0 with mem_stall=1 for 3 cycles:
  - Outputs stall=1, bubble=0; stall_cycles unchanged.
  - After release: one hazard stall, then sel=2.
- FWD_EN=0: ALU rd=5 followed by a use of 5 -> 2 stall cycles (entry at k=0, then k=1). Released at k=2 with sel=0; stall_cycles=2.
- Taken branch with no hazard -> flush_ifid=1, flush_count=1. Taken branch plus load-use -> flush 0 while stalled, then 1. Pull rst_n low with a pending load -> stall drops to 0 immediately and counters read 0.
